// File: rtl/data_break_if.sv
// Requester-side bus of the data-break controller: per-requester request,
// direction, address and write data in; grant, ack and read data out.
interface data_break_if #(
  parameter int NREQ = 4
);
  logic [0:NREQ-1]    brk_req;
  logic [0:NREQ-1]    brk_dir;
  logic [0:15*NREQ-1] brk_addr;
  logic [0:12*NREQ-1] brk_wdata;
  logic [0:NREQ-1]    brk_gnt;
  logic [0:NREQ-1]    brk_ack;
  logic [0:11]        brk_rdata;

  modport master (
    output brk_req, brk_dir, brk_addr, brk_wdata,
    input  brk_gnt, brk_ack, brk_rdata
  );

  modport slave (
    input  brk_req, brk_dir, brk_addr, brk_wdata,
    output brk_gnt, brk_ack, brk_rdata
  );
endinterface

// File: rtl/data_break.sv
// data_break: PDP-8/E data-break (DMA) controller. Steals one memory cycle
// per slot (or back-to-back while halted) for the winning requester.
// Optional macro DATA_BREAK_RR_EN: round-robin priority; otherwise fixed
// priority with the lowest index winning.
module data_break #(
  parameter int NREQ     = 4,
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        slot,
  input  logic        halted,
  data_break_if.slave brk,
  input  logic [0:11] mem_rdata,
  output logic        hold,
  output logic        mem_sel,
  output logic [0:2]  mem_ema,
  output logic [0:11] mem_ma,
  output logic [0:11] mem_wdata,
  output logic        mem_we
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MEM_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ACCESS, S_CAPT, S_RELEASE} state_t;

  state_t        st, st_nxt;
  logic [IW-1:0] win_idx, lat_idx;
  logic          win_vld, start, busy;
  logic          lat_dir;
  logic [0:14]   lat_addr;
  logic [0:11]   lat_wdata, rdata_q;
  logic [CW-1:0] cnt;

  // A break may only be latched from IDLE; clear blocks it there.
  assign start = (slot | halted) & win_vld & ~clear;

`ifdef DATA_BREAK_RR_EN
  logic [IW-1:0] ptr;

  // Priority pointer: last granted index, rewound by reset or clear in IDLE.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= IW'(NREQ - 1);
    else if (st == S_IDLE) begin
      if (clear)
        ptr <= IW'(NREQ - 1);
      else if (start)
        ptr <= win_idx;
    end
  end
`endif

  // Winner search over the live request vector.
  always_comb begin : arb
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef DATA_BREAK_RR_EN
      j = (int'(ptr) + 1 + k) % NREQ;
`else
      j = k;
`endif
      if (!win_vld && brk.brk_req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  // Next-state decode; clear outside IDLE is deliberately ignored.
  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:    if (start) st_nxt = S_ARB;
      S_ARB:     st_nxt = S_ACCESS;
      S_ACCESS:  if (cnt == CW'(1)) st_nxt = S_CAPT;
      S_CAPT:    st_nxt = S_RELEASE;
      S_RELEASE: st_nxt = S_IDLE;
      default:   st_nxt = S_IDLE;
    endcase
  end

  // Transaction latch, access-wait counter and read-data capture. Read data
  // is sampled in the last ACCESS cycle so it is visible alongside the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_idx   <= '0;
      lat_dir   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      if (st == S_IDLE && start) begin
        lat_idx   <= win_idx;
        lat_dir   <= brk.brk_dir[win_idx];
        lat_addr  <= brk.brk_addr[15*int'(win_idx) +: 15];
        lat_wdata <= brk.brk_wdata[12*int'(win_idx) +: 12];
      end
      if (st == S_ARB)
        cnt <= CW'(MEM_WAIT);
      else if (st == S_ACCESS)
        cnt <= cnt - CW'(1);
      if (st == S_ACCESS && cnt == CW'(1) && !lat_dir)
        rdata_q <= mem_rdata;
    end
  end

  // Outputs decoded purely from registered state and latched data.
  assign busy      = (st == S_ARB) || (st == S_ACCESS) || (st == S_CAPT);
  assign hold      = busy;
  assign mem_sel   = busy;
  assign mem_ema   = busy ? lat_addr[0:2]  : '0;
  assign mem_ma    = busy ? lat_addr[3:14] : '0;
  assign mem_wdata = busy ? lat_wdata      : '0;
  assign mem_we    = (st == S_ACCESS) && (cnt == CW'(MEM_WAIT)) && lat_dir;
  assign brk.brk_rdata = rdata_q;

  // One-hot grant for the whole transaction, ack pulse in CAPT.
  always_comb begin
    brk.brk_gnt = '0;
    brk.brk_ack = '0;
    if (busy)         brk.brk_gnt[lat_idx] = 1'b1;
    if (st == S_CAPT) brk.brk_ack[lat_idx] = 1'b1;
  end
endmodule

// File: tb/tb_data_break.sv
// Randomized self-checking bench for data_break against a transaction-level
// reference model (winner choice, memory image, expected read data).
module tb_data_break;
  localparam int NREQ = 4;
  localparam int MW   = 2;

  logic        clk = 1'b0;
  logic        reset, clear, slot, halted;
  logic [0:11] mem_rdata, mem_ma, mem_wdata;
  logic [0:2]  mem_ema;
  logic        hold, mem_sel, mem_we;

  data_break_if #(.NREQ(NREQ)) bif();

  data_break #(.NREQ(NREQ), .MEM_WAIT(MW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .slot     (slot),
    .halted   (halted),
    .brk      (bif.slave),
    .mem_rdata(mem_rdata),
    .hold     (hold),
    .mem_sel  (mem_sel),
    .mem_ema  (mem_ema),
    .mem_ma   (mem_ma),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we)
  );

  always #5 clk = ~clk;

  // Device memory (the thing the DUT talks to).
  logic [11:0] dev_mem [0:32767];
  logic        pre_init, pre_wr;
  logic [14:0] pre_a;
  logic [11:0] pre_d;

  assign mem_rdata = dev_mem[{mem_ema, mem_ma}];

  always @(posedge clk) begin
    if (pre_init)
      for (int i = 0; i < 32768; i++) dev_mem[i] <= 12'(i * 37 + 5);
    if (pre_wr) dev_mem[pre_a] <= pre_d;
    if (mem_we) dev_mem[{mem_ema, mem_ma}] <= mem_wdata;
  end

  // Reference model state.
  logic [11:0] ref_mem [0:32767];
  logic [11:0] ref_rdata;
  int          last;
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [0:NREQ-1] req);
`ifdef DATA_BREAK_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (req[k]) return k;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic dir, input logic [14:0] a, input logic [11:0] d);
    bif.brk_dir[i]             = dir;
    bif.brk_addr[15*i +: 15]   = a;
    bif.brk_wdata[12*i +: 12]  = d;
  endtask

  // Called at the negedge of an IDLE cycle with the trigger already applied.
  // Walks ARB..RELEASE and checks every output each cycle.
  task automatic run_txn(input bit drop, input int clr_at);
    int              w;
    logic            dir;
    logic [14:0]     a;
    logic [11:0]     d, exp_rd;
    logic [0:NREQ-1] oh;
    chk("idle_hold", {31'b0, hold}, 0);
    w = pick(bif.brk_req);
    if (w < 0) w = 0;
    dir = bif.brk_dir[w];
    a   = bif.brk_addr[15*w +: 15];
    d   = bif.brk_wdata[12*w +: 12];
    last = w;
    oh = '0;
    oh[w] = 1'b1;
    if (dir) ref_mem[a] = d;
    else     ref_rdata  = ref_mem[a];
    exp_rd = ref_rdata;
    for (int c = 1; c <= MW + 3; c++) begin
      @(negedge clk);
      slot  = 1'b0;
      clear = (c == clr_at);
      chk("hold",    {31'b0, hold},    (c <= MW + 2) ? 1 : 0);
      chk("mem_sel", {31'b0, mem_sel}, (c <= MW + 2) ? 1 : 0);
      chk("gnt",     {28'b0, bif.brk_gnt}, (c <= MW + 2) ? {28'b0, oh} : 32'b0);
      chk("we",      {31'b0, mem_we},  (c == 2 && dir) ? 1 : 0);
      chk("ack",     {28'b0, bif.brk_ack}, (c == MW + 2) ? {28'b0, oh} : 32'b0);
      if (c <= MW + 2) begin
        chk("ema", {29'b0, mem_ema}, {29'b0, a[14:12]});
        chk("ma",  {20'b0, mem_ma},  {20'b0, a[11:0]});
      end
      if (c == 2 && dir) chk("wdata", {20'b0, mem_wdata}, {20'b0, d});
      if (c >= MW + 2)   chk("rdata", {20'b0, bif.brk_rdata}, {20'b0, exp_rd});
      if (c == MW + 2 && drop) bif.brk_req[w] = 1'b0;
    end
    clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; clear = 1'b0; slot = 1'b0; halted = 1'b0;
    pre_init = 1'b1; pre_wr = 1'b0; pre_a = '0; pre_d = '0;
    bif.brk_req = '0; bif.brk_dir = '0; bif.brk_addr = '0; bif.brk_wdata = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 12'(i * 37 + 5);
    ref_rdata = '0;
    last = NREQ - 1;
    repeat (3) @(negedge clk);
    pre_init = 1'b0;

    // Reset state
    chk("rst_hold",  {31'b0, hold}, 0);
    chk("rst_sel",   {31'b0, mem_sel}, 0);
    chk("rst_we",    {31'b0, mem_we}, 0);
    chk("rst_gnt",   {28'b0, bif.brk_gnt}, 0);
    chk("rst_ack",   {28'b0, bif.brk_ack}, 0);
    chk("rst_rdata", {20'b0, bif.brk_rdata}, 0);
    chk("rst_ma",    {20'b0, mem_ma}, 0);
    reset = 1'b0;

    // Request without slot/halted never holds the CPU
    bif.brk_req[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("noslot_hold", {31'b0, hold}, 0);
    end
    bif.brk_req = '0;

    // Directed read: requester 2, {1, 0200}, memory holds 7421
    pre_wr = 1'b1; pre_a = 15'o10200; pre_d = 12'o7421;
    ref_mem[15'o10200] = 12'o7421;
    @(negedge clk);
    pre_wr = 1'b0;
    set_req(2, 1'b0, 15'o10200, 12'o0000);
    bif.brk_req[2] = 1'b1;
    slot = 1'b1;
    run_txn(1'b1, 0);
    chk("rd_7421", {20'b0, bif.brk_rdata}, 32'o7421);
    @(negedge clk);

    // Directed write: requester 0, 0017 <- 5555
    set_req(0, 1'b1, 15'o00017, 12'o5555);
    bif.brk_req[0] = 1'b1;
    slot = 1'b1;
    run_txn(1'b1, 0);
    @(negedge clk);
    chk("wr_mem", {20'b0, dev_mem[15'o00017]}, 32'o5555);
    chk("wr_keep_rdata", {20'b0, bif.brk_rdata}, 32'o7421);

    // clear with slot and request pending: no grant, pointer rewinds
    bif.brk_req[1] = 1'b1;
    clear = 1'b1; slot = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("clr_hold", {31'b0, hold}, 0);
      chk("clr_gnt",  {28'b0, bif.brk_gnt}, 0);
    end
    clear = 1'b0; slot = 1'b0;
    last = NREQ - 1;
    @(negedge clk);
    chk("clr_after_hold", {31'b0, hold}, 0);
    bif.brk_req = '0;

    // Contention while halted, all requesting continuously
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 15'(i + 3), 12'(i));
    bif.brk_req = '1;
    halted = 1'b1;
    for (int n = 0; n < 5; n++) begin
      run_txn(1'b0, 0);
      if (n == 4) halted = 1'b0;
      @(negedge clk);
    end
    bif.brk_req = '0;
    @(negedge clk);

    // clear during ACCESS: transaction still completes and acks
    set_req(3, 1'b0, 15'o00005, 12'o0);
    bif.brk_req[3] = 1'b1;
    slot = 1'b1;
    run_txn(1'b1, 2);
    @(negedge clk);

    // reset during ACCESS: back to IDLE, no ack
    set_req(1, 1'b0, 15'o00006, 12'o0);
    bif.brk_req[1] = 1'b1;
    slot = 1'b1;
    @(negedge clk);
    slot = 1'b0;
    chk("rstacc_arb_hold", {31'b0, hold}, 1);
    @(negedge clk);
    chk("rstacc_acc_hold", {31'b0, hold}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bif.brk_req = '0;
    ref_rdata = '0;
    last = NREQ - 1;
    chk("rstacc_hold",  {31'b0, hold}, 0);
    chk("rstacc_gnt",   {28'b0, bif.brk_gnt}, 0);
    chk("rstacc_rdata", {20'b0, bif.brk_rdata}, 0);
    repeat (6) begin
      @(negedge clk);
      chk("rstacc_ack", {28'b0, bif.brk_ack}, 0);
    end

    // Randomized transactions over a small address window
    for (int n = 0; n < 40; n++) begin
      logic [0:NREQ-1] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom), 15'($urandom_range(0, 15)), 12'($urandom));
      bif.brk_req = m;
      if ($urandom_range(0, 1) == 1) halted = 1'b1;
      else                           slot   = 1'b1;
      run_txn(1'b1, 0);
      halted = 1'b0; slot = 1'b0;
      bif.brk_req = '0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        chk("gap_hold", {31'b0, hold}, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
